// File: rtl/window_loader_pkg.sv
// Shared definitions for the window loader: scan FSM states and memory packing.
package window_loader_pkg;

  localparam int PIX_PER_WORD = 2;
  localparam int CACHE_WORDS  = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_REFILL,
    ST_SETTLE,
    ST_PRESENT,
    ST_SHIFT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/window_loader_addr_gen.sv
// Word address of a pixel pair: base + row * words_per_row + word.
module win_addr_gen
  import window_loader_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int AW    = 16
) (
  input  logic [AW-1:0] base,
  input  logic [15:0]   row,
  input  logic [15:0]   word,
  output logic [AW-1:0] addr
);

  localparam int WPR = IMG_W / PIX_PER_WORD;

  assign addr = base + AW'(32'(row) * 32'(WPR)) + AW'(word);

endmodule

// File: rtl/window_loader.sv
// Scans an image in raster order, filling a 3-row colour cache from word memory
// and presenting each 3x3 window with a valid/ready handshake.
module window_loader
  import window_loader_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int AW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  input  logic [15:0]   mem_rdata,
  output logic          cache_we,
  output logic [2:0]    cache_addr,
  output logic [15:0]   cache_di,
  output logic          cache_sh,
  output logic          win_valid,
  input  logic          win_ready,
  output logic [15:0]   win_row,
  output logic [15:0]   win_col,
  output logic          busy,
  output logic          done
);

  localparam logic [15:0] LAST_COL = 16'(IMG_W - 3);
  localparam logic [15:0] LAST_ROW = 16'(IMG_H - 3);

  state_e        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [15:0]   row_q, row_d;
  logic [15:0]   col_q, col_d;
  logic [AW-1:0] base_q, base_d;

  logic [15:0]   ag_row, ag_word;
  logic [AW-1:0] ag_addr;

  win_addr_gen #(.IMG_W(IMG_W), .AW(AW)) u_addr_gen (
    .base (base_q),
    .row  (ag_row),
    .word (ag_word),
    .addr (ag_addr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      col_q   <= col_d;
      base_q  <= base_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    row_d      = row_q;
    col_d      = col_q;
    base_d     = base_q;
    mem_rd     = 1'b0;
    cache_we   = 1'b0;
    cache_addr = '0;
    cache_sh   = 1'b0;
    win_valid  = 1'b0;
    done       = 1'b0;
    busy       = (state_q != ST_IDLE);
    ag_row     = row_q;
    ag_word    = '0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d  = base;
          row_d   = '0;
          col_d   = '0;
          cnt_d   = '0;
          state_d = ST_LOAD;
        end
      end
      // cnt 0..5 issues reads; each read lands in the cache one cycle later (cnt 1..6)
      ST_LOAD: begin
        ag_row  = row_q + 16'(cnt_q[2:1]);
        ag_word = 16'(cnt_q[0]);
        mem_rd  = (cnt_q < 3'd6);
        if (cnt_q != 3'd0) begin
          cache_we   = 1'b1;
          cache_addr = cnt_q - 3'd1;
        end
        if (cnt_q == 3'd6) begin
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      // Only the right-hand word of each row is stale after two shifts
      ST_REFILL: begin
        ag_row  = row_q + 16'(cnt_q);
        ag_word = (col_q >> 1) + 16'd1;
        mem_rd  = (cnt_q < 3'd3);
        if (cnt_q != 3'd0) begin
          cache_we   = 1'b1;
          cache_addr = (cnt_q << 1) - 3'd1;
        end
        if (cnt_q == 3'd3) begin
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == 3'd1) begin
          cnt_d   = '0;
          state_d = ST_PRESENT;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_PRESENT: begin
        win_valid = 1'b1;
        if (win_ready) begin
          if (col_q != LAST_COL) begin
            state_d = ST_SHIFT;
          end else if (row_q != LAST_ROW) begin
            row_d   = row_q + 16'd1;
            col_d   = '0;
            cnt_d   = '0;
            state_d = ST_LOAD;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        cache_sh = 1'b1;
        col_d    = col_q + 16'd1;
        cnt_d    = '0;
        state_d  = col_q[0] ? ST_REFILL : ST_SETTLE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_addr = mem_rd    ? ag_addr   : '0;
  assign cache_di = cache_we  ? mem_rdata : '0;
  assign win_row  = win_valid ? row_q     : '0;
  assign win_col  = win_valid ? col_q     : '0;

endmodule
